// File: rtl/input_pkg.sv
// Shared types for the input command queue: command encoding, arbiter
// priority order and the priority-select helper.
package input_pkg;

  typedef enum logic [1:0] {
    CMD_UP    = 2'd0,
    CMD_DOWN  = 2'd1,
    CMD_LEFT  = 2'd2,
    CMD_RIGHT = 2'd3
  } cmd_t;

  localparam int unsigned NUM_DIRS = 4;

  // Highest priority first.
  localparam cmd_t PRIO_ORDER [NUM_DIRS] = '{CMD_DOWN, CMD_LEFT, CMD_RIGHT, CMD_UP};

  // Returns the highest-priority pending direction (CMD_UP if none pending;
  // callers qualify with |pend).
  function automatic cmd_t arb_select(input logic [NUM_DIRS-1:0] pend);
    cmd_t sel;
    logic found;
    sel   = CMD_UP;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_DIRS; i++) begin
      if (!found && pend[PRIO_ORDER[i]]) begin
        sel   = PRIO_ORDER[i];
        found = 1'b1;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous FIFO of command codes. Push while full is accepted only when a
// pop happens on the same edge; pop while empty is ignored.
module cmd_fifo
  import input_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  cmd_t                     din,
  input  logic                     pop,
  output cmd_t                     dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PW = $clog2(DEPTH);
  typedef logic [PW-1:0] ptr_t;
  typedef logic [PW:0]   lvl_t;

  cmd_t mem_q [DEPTH];
  cmd_t mem_d [DEPTH];
  ptr_t wr_ptr_q, wr_ptr_d;
  ptr_t rd_ptr_q, rd_ptr_d;
  lvl_t level_q, level_d;
  logic do_push;
  logic do_pop;

  assign full  = (level_q == lvl_t'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;
  assign dout  = mem_q[rd_ptr_q];

  // Next-state for storage, pointers (natural power-of-two wrap) and occupancy.
  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + ptr_t'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + ptr_t'(1);
    end
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + lvl_t'(1);
      2'b01:   level_d = level_q - lvl_t'(1);
      default: level_d = level_q;
    endcase
  end

  // State registers; reset clears storage so the head reads CMD_UP.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= CMD_UP;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/input_cmd_queue.sv
// Button-press command queue: per-direction pending bits, fixed-priority
// arbiter (down > left > right > up) and a command FIFO.
// Optional feature: define INPUT_CMD_QUEUE_STATS_EN to add the drop_cnt
// output counting presses merged into an already-pending direction.
module input_cmd_queue
  import input_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     up,
  input  logic                     down,
  input  logic                     left,
  input  logic                     right,
  output logic [1:0]               cmd,
  output logic                     cmd_valid,
  input  logic                     cmd_ready,
  output logic [$clog2(DEPTH):0]   level
`ifdef INPUT_CMD_QUEUE_STATS_EN
  ,
  output logic [7:0]               drop_cnt
`endif
);

  logic [NUM_DIRS-1:0] pulse;
  logic [NUM_DIRS-1:0] pend_q, pend_d;
  logic [NUM_DIRS-1:0] clr;
  cmd_t                sel;
  cmd_t                fifo_dout;
  logic                fifo_full;
  logic                fifo_empty;
  logic                push;
  logic                pop;

  // Bit positions follow the cmd_t encoding.
  assign pulse     = {right, left, down, up};
  assign cmd_valid = !fifo_empty;
  assign cmd       = fifo_dout;
  assign pop       = cmd_valid && cmd_ready;

  // Arbitration and pending update; a pulse coinciding with its own clear
  // re-arms the bit so it becomes a second entry.
  always_comb begin
    sel  = arb_select(pend_q);
    push = (|pend_q) && (!fifo_full || pop);
    clr  = '0;
    if (push) begin
      clr[sel] = 1'b1;
    end
    pend_d = pulse | (pend_q & ~clr);
  end

  // Pending-bit register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

`ifdef INPUT_CMD_QUEUE_STATS_EN
  logic [7:0]          drop_cnt_q, drop_cnt_d;
  logic [NUM_DIRS-1:0] merged;
  logic [8:0]          drop_sum;

  assign drop_cnt = drop_cnt_q;

  // Count presses absorbed by a still-pending bit, saturating at 255.
  always_comb begin
    merged   = pulse & pend_q & ~clr;
    drop_sum = {1'b0, drop_cnt_q};
    for (int unsigned i = 0; i < NUM_DIRS; i++) begin
      drop_sum = drop_sum + {8'd0, merged[i]};
    end
    drop_cnt_d = (drop_sum > 9'd255) ? 8'd255 : drop_sum[7:0];
  end

  // Drop counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end
`endif

  cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (sel),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

endmodule

// File: tb/tb_input_cmd_queue.sv
// Directed bench for input_cmd_queue with hand-computed expectations.
module tb_input_cmd_queue;

  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       up, down, left, right;
  logic [1:0] cmd;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] level;
`ifdef INPUT_CMD_QUEUE_STATS_EN
  logic [7:0] drop_cnt;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  input_cmd_queue #(
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .up        (up),
    .down      (down),
    .left      (left),
    .right     (right),
    .cmd       (cmd),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .level     (level)
`ifdef INPUT_CMD_QUEUE_STATS_EN
    ,
    .drop_cnt  (drop_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic btn(input logic u, input logic d, input logic l, input logic r);
    up    = u;
    down  = d;
    left  = l;
    right = r;
  endtask

  task automatic pulse(input logic u, input logic d, input logic l, input logic r);
    btn(u, d, l, r);
    step();
    btn(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Checks valid and level always, head command only when valid.
  task automatic expect_q(input string tag, input logic v, input logic [1:0] c, input logic [2:0] lv);
    check({tag, ".valid"}, cmd_valid, v);
    check({tag, ".level"}, level, lv);
    if (v) check({tag, ".cmd"}, cmd, c);
  endtask

  task automatic expect_drop(input string tag, input logic [7:0] exp);
`ifdef INPUT_CMD_QUEUE_STATS_EN
    check(tag, drop_cnt, exp);
`endif
  endtask

  logic [1:0] seq4 [4];
  logic [2:0] lvl5 [5];
  logic [1:0] seq5 [5];

  initial begin
    rst = 1'b1;
    cmd_ready = 1'b0;
    btn(1'b0, 1'b0, 1'b0, 1'b0);
    step();
    step();
    check("rst.valid", cmd_valid, 1'b0);
    check("rst.level", level, 3'd0);
    check("rst.cmd", cmd, 2'd0);
    expect_drop("rst.drop", 8'd0);
    rst = 1'b0;
    step();
    expect_q("idle", 1'b0, 2'd0, 3'd0);

    // Single left press, consumer ready: valid for exactly one cycle.
    cmd_ready = 1'b1;
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    expect_q("lat.n1", 1'b0, 2'd0, 3'd0);
    step();
    expect_q("lat.n2", 1'b1, 2'd2, 3'd1);
    step();
    expect_q("lat.n3", 1'b0, 2'd0, 3'd0);

    // All four at once, consumer stalled: priority order down,left,right,up.
    cmd_ready = 1'b0;
    pulse(1'b1, 1'b1, 1'b1, 1'b1);
    check("prio.l0", level, 3'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      expect_q("prio.fill", 1'b1, 2'd1, 3'(k + 1));
    end
    seq4 = '{2'd1, 2'd2, 2'd3, 2'd0};
    cmd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      expect_q("prio.pop", 1'b1, seq4[i], 3'(4 - i));
      step();
    end
    expect_q("prio.empty", 1'b0, 2'd0, 3'd0);
    cmd_ready = 1'b0;

    // Five separate presses into DEPTH=4: fifth held pending until a pop.
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    expect_q("full.l4", 1'b1, 2'd1, 3'd4);
    for (int k = 0; k < 3; k++) begin
      step();
      expect_q("full.hold", 1'b1, 2'd1, 3'd4);
    end
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    expect_q("full.pushpop", 1'b1, 2'd2, 3'd4);
    seq4 = '{2'd2, 2'd3, 2'd0, 2'd1};
    cmd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      expect_q("full.drain", 1'b1, seq4[i], 3'(4 - i));
      step();
    end
    expect_q("full.empty", 1'b0, 2'd0, 3'd0);
    cmd_ready = 1'b0;

    // Repeated right press while full merges into one entry.
    pulse(1'b1, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) step();
    check("merge.full", level, 3'd4);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    check("merge.l4", level, 3'd4);
    expect_drop("merge.drop", 8'd1);
    step();
    step();
    check("merge.hold", level, 3'd4);
    seq5 = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd3};
    lvl5 = '{3'd4, 3'd4, 3'd3, 3'd2, 3'd1};
    cmd_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      expect_q("merge.drain", 1'b1, seq5[i], lvl5[i]);
      step();
    end
    expect_q("merge.empty", 1'b0, 2'd0, 3'd0);
    cmd_ready = 1'b0;

    // Press again in the cycle its pending bit is pushed: two entries.
    btn(1'b0, 1'b0, 1'b0, 1'b1);
    step();
    step();
    btn(1'b0, 1'b0, 1'b0, 1'b0);
    expect_q("rearm.e2", 1'b1, 2'd3, 3'd1);
    step();
    expect_q("rearm.e3", 1'b1, 2'd3, 3'd2);
    step();
    expect_q("rearm.e4", 1'b1, 2'd3, 3'd2);
    expect_drop("rearm.drop", 8'd1);
    cmd_ready = 1'b1;
    expect_q("rearm.pop0", 1'b1, 2'd3, 3'd2);
    step();
    expect_q("rearm.pop1", 1'b1, 2'd3, 3'd1);
    step();
    expect_q("rearm.empty", 1'b0, 2'd0, 3'd0);
    cmd_ready = 1'b0;

    // Mid-operation reset with queued and pending commands.
    pulse(1'b0, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) step();
    pulse(1'b1, 1'b1, 1'b0, 1'b0);
    expect_q("mrst.pre", 1'b1, 2'd1, 3'd3);
    rst = 1'b1;
    cmd_ready = 1'b1;
    btn(1'b0, 1'b0, 1'b1, 1'b0);
    step();
    rst = 1'b0;
    btn(1'b0, 1'b0, 1'b0, 1'b0);
    expect_q("mrst.post", 1'b0, 2'd0, 3'd0);
    check("mrst.cmd", cmd, 2'd0);
    expect_drop("mrst.drop", 8'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      expect_q("mrst.stale", 1'b0, 2'd0, 3'd0);
    end
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    expect_q("mrst.n1", 1'b0, 2'd0, 3'd0);
    step();
    expect_q("mrst.n2", 1'b1, 2'd3, 3'd1);
    step();
    expect_q("mrst.n3", 1'b0, 2'd0, 3'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
